// File: rtl/sp_ram_be_clr.sv
// Single-port synchronous RAM with byte-lane writes, selectable read-during-write,
// optional output register and a clear engine that fills every word with init_val.
//   state | meaning
//   CLEAR | clear engine walks cnt over every word; port accesses dropped
//   READY | normal read/write service
module sp_ram_be_clr #(
    parameter int data_width = 32,
    parameter int add_width  = 4,
    parameter int byte_width = 8,
    parameter int rdw_mode   = 0,
    parameter int out_reg    = 0,
    parameter logic [data_width-1:0] init_val = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [data_width-1:0]            data,
    input  logic [add_width-1:0]             addr,
    input  logic [data_width/byte_width-1:0] be,
    input  logic                             write_ena,
    input  logic                             read_ena,
    input  logic                             clr_req,
    output logic [data_width-1:0]            q,
    output logic                             q_valid,
    output logic                             busy
);
    localparam int nb    = data_width / byte_width;
    localparam int depth = 2 ** add_width;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                state, state_next;
    logic [add_width-1:0]  cnt, cnt_next;
    logic [data_width-1:0] ram [depth];
    logic                  accept;
    logic                  do_write;
    logic [data_width-1:0] merged;
    logic [data_width-1:0] rd_data;
    logic                  rd_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // clr_req in READY takes priority over any access in the same cycle
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            CLEAR: begin
                cnt_next = cnt + 1'b1;
                if (&cnt)
                    state_next = READY;
            end
            READY: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end else begin
                    accept = write_ena | read_ena;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    assign do_write = accept & write_ena;
    assign busy     = (state == CLEAR);

    always_comb begin
        merged = ram[addr];
        for (int i = 0; i < nb; i++) begin
            if (be[i])
                merged[i*byte_width +: byte_width] = data[i*byte_width +: byte_width];
        end
    end

    // The array itself has no reset; the clear engine initialises it after every reset.
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            ram[cnt] <= init_val;
        else if (do_write)
            ram[addr] <= merged;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= accept;
            if (accept)
                rd_data <= (rdw_mode != 0 && write_ena) ? merged : ram[addr];
        end
    end

    generate
        if (out_reg == 0) begin : g_direct
            assign q       = rd_data;
            assign q_valid = rd_valid;
        end else begin : g_piped
            logic [data_width-1:0] q_reg;
            logic                  q_valid_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_reg       <= '0;
                    q_valid_reg <= 1'b0;
                end else begin
                    q_valid_reg <= rd_valid;
                    if (rd_valid)
                        q_reg <= rd_data;
                end
            end

            assign q       = q_reg;
            assign q_valid = q_valid_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sp_ram_be_clr.sv
// Two RAM instances (read-first/direct output, write-first/registered output) driven
// in parallel and compared every cycle against a word-array reference model.
module tb_sp_ram_be_clr;
    localparam int DEPTH = 16;
    localparam logic [31:0] INIT = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data = '0;
    logic [3:0]  addr = '0;
    logic [3:0]  be = '0;
    logic        write_ena = 1'b0;
    logic        read_ena = 1'b0;
    logic        clr_req = 1'b0;
    logic [31:0] q0, q1;
    logic        v0, v1, busy0, busy1;

    always #5 clk = ~clk;

    sp_ram_be_clr #(.data_width(32), .add_width(4), .byte_width(8),
                    .rdw_mode(0), .out_reg(0), .init_val(INIT)) dut0 (
        .clk(clk), .rst(rst), .data(data), .addr(addr), .be(be),
        .write_ena(write_ena), .read_ena(read_ena), .clr_req(clr_req),
        .q(q0), .q_valid(v0), .busy(busy0));

    sp_ram_be_clr #(.data_width(32), .add_width(4), .byte_width(8),
                    .rdw_mode(1), .out_reg(1), .init_val(INIT)) dut1 (
        .clk(clk), .rst(rst), .data(data), .addr(addr), .be(be),
        .write_ena(write_ena), .read_ena(read_ena), .clr_req(clr_req),
        .q(q1), .q_valid(v1), .busy(busy1));

    // reference model state
    logic [31:0] mem_m [DEPTH];
    int          clr_left;
    logic [31:0] exp_q0, exp_q1, pend_d;
    logic        exp_v0, exp_v1, pend_v;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0] lanes);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++)
            if (lanes[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        clr_left = DEPTH;
        exp_q0 = '0; exp_v0 = 1'b0;
        exp_q1 = '0; exp_v1 = 1'b0;
        pend_d = '0; pend_v = 1'b0;
    endtask

    task automatic model_edge();
        logic        rd;
        logic [31:0] res0, res1, nw;
        rd = 1'b0; res0 = '0; res1 = '0;
        if (rst) return;
        if (clr_left > 0) begin
            mem_m[DEPTH - clr_left] = INIT;
            clr_left--;
        end else if (clr_req) begin
            clr_left = DEPTH;
        end else if (write_ena || read_ena) begin
            rd   = 1'b1;
            res0 = mem_m[addr];
            nw   = lane_merge(mem_m[addr], data, be);
            res1 = write_ena ? nw : mem_m[addr];
            if (write_ena) mem_m[addr] = nw;
        end
        exp_v0 = rd;
        if (rd) exp_q0 = res0;
        exp_v1 = pend_v;
        if (pend_v) exp_q1 = pend_d;
        pend_v = rd;
        pend_d = res1;
    endtask

    task automatic check_outputs();
        chk("busy0", {31'b0, busy0}, {31'b0, clr_left > 0});
        chk("busy1", {31'b0, busy1}, {31'b0, clr_left > 0});
        chk("q_valid0", {31'b0, v0}, {31'b0, exp_v0});
        chk("q_valid1", {31'b0, v1}, {31'b0, exp_v1});
        chk("q0", q0, exp_q0);
        chk("q1", q1, exp_q1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_outputs();
    endtask

    task automatic acc(input logic we, input logic re, input logic cr,
                       input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        write_ena = we; read_ena = re; clr_req = cr;
        addr = a; data = d; be = b;
        step();
    endtask

    task automatic idle();
        acc(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
    endtask

    task automatic do_reset(input int hold);
        rst = 1'b1;
        #2;
        model_reset();
        check_outputs();
        repeat (hold) step();
        rst = 1'b0;
    endtask

    task automatic count_busy(input string tag);
        int n;
        n = 0;
        while (busy0 && n < 40) begin
            step();
            n++;
        end
        chk(tag, n, 16);
    endtask

    initial begin
        model_reset();
        do_reset(2);
        count_busy("busy_len_reset");

        for (int a = 0; a < DEPTH; a++) acc(1'b0, 1'b1, 1'b0, 4'(a), 32'd0, 4'd0);
        idle();
        idle();

        // byte lanes over init value
        acc(1'b1, 1'b0, 1'b0, 4'd3, 32'h11223344, 4'b0101);
        acc(1'b0, 1'b1, 1'b0, 4'd3, 32'd0, 4'd0);
        chk("be_merge", q0, 32'hA522A544);
        idle();

        // read during write at addr 5 holding zero
        acc(1'b1, 1'b0, 1'b0, 4'd5, 32'h0, 4'hF);
        acc(1'b1, 1'b1, 1'b0, 4'd5, 32'hDEADBEEF, 4'hF);
        chk("rdw_old", q0, 32'h0);
        idle();
        chk("rdw_new", q1, 32'hDEADBEEF);

        // back-to-back reads through the registered output
        acc(1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 4'd0);
        acc(1'b0, 1'b1, 1'b0, 4'd1, 32'd0, 4'd0);
        acc(1'b0, 1'b1, 1'b0, 4'd2, 32'd0, 4'd0);
        idle();
        idle();

        // clear wins over a same-cycle write, then write attempts during busy
        acc(1'b1, 1'b0, 1'b0, 4'd7, 32'h12345678, 4'hF);
        acc(1'b1, 1'b1, 1'b1, 4'd7, 32'hCAFEF00D, 4'hF);
        for (int i = 0; i < 15; i++) acc(1'b1, 1'b1, 1'b0, 4'(i), 32'hFFFF0000, 4'hF);
        idle();
        acc(1'b0, 1'b1, 1'b0, 4'd7, 32'd0, 4'd0);
        chk("clr_wins", q0, INIT);
        idle();

        // reset mid-clear at count 9
        acc(1'b0, 1'b0, 1'b1, 4'd0, 32'd0, 4'd0);
        repeat (9) acc(1'b1, 1'b0, 1'b0, 4'd2, 32'h0BAD0BAD, 4'hF);
        do_reset(1);
        count_busy("busy_len_midclr");

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            acc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 59) == 0), 4'($urandom_range(0, 15)),
                32'($urandom), 4'($urandom_range(0, 15)));
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sp_ram_be_clr.md
# sp_ram_be_clr

Parametrised single-port synchronous RAM, successor to the team's basic 8-bit single-port RAM. Adds byte-lane write enables, a selectable read-during-write mode, an optional output register stage, a qualified read-valid strobe, and a hardware clear engine. The clear engine initialises every word after reset or on request. It sits as a local scratch/buffer memory behind simple datapath controllers that must not see stale contents.

## Interface
- data_width, 32: word width in bits; must be a multiple of byte_width
- add_width, 4: address width; depth = 2**add_width
- byte_width, 8: bits per byte lane; lanes NB = data_width/byte_width
- rdw_mode, 0: same-address read during write; 0 = old data (read-first), 1 = new merged data (write-first)
- out_reg, 0: 0 = 1-cycle read latency, 1 = extra output register, 2-cycle latency
- init_val, 0: word value written by the clear engine
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- data  input  data_width  write data
- addr  input  add_width  word address
- be  input  NB  byte-lane write enables; bit i covers data[i*byte_width +: byte_width]
- write_ena  input  1  write request
- read_ena  input  1  read request
- clr_req  input  1  start a full clear
- q  output  data_width  read data
- q_valid  output  1  one-cycle strobe; q carries a new read result
- busy  output  1  clear engine active; accesses are ignored

## Operation
- FSM states: CLEAR and READY.
- rst asserted: state = CLEAR, clear counter = 0, q = 0, q_valid = 0, busy = 1, output pipeline register = 0. The memory array is not reset.
- CLEAR: on each rising edge, ram[cnt] <= init_val and cnt increments. On the edge where cnt = 2**add_width-1, the FSM moves to READY and busy goes to 0. cnt wraps to 0.
- READY with clr_req = 1: go to CLEAR with cnt = 0. Any write_ena/read_ena in that same cycle is dropped, so clear wins.
- CLEAR ignores write_ena, read_ena and clr_req. No array write from the port, q holds, q_valid = 0.
- READY write: write_ena = 1 updates only the lanes with be[i] = 1. be = 0 performs no write but is still a legal cycle.
- READY read: read_ena = 1 or write_ena = 1 registers a read of ram[addr] and pulses q_valid at the result latency. A write therefore also returns read data.
- Read during write at the same address:
  - rdw_mode = 0: q = pre-write word.
  - rdw_mode = 1: q = the pre-write word with the enabled lanes replaced by data.
- With neither read_ena nor write_ena: q holds its last value and q_valid = 0.
- Out-of-range addresses cannot occur because depth is a full power of two.

## Timing
- Clear duration: busy = 1 from rst assertion until exactly 2**add_width rising edges after rst deasserts. The first port access is accepted on the first edge at which busy is sampled 0.
- A clr_req accepted at edge N drives busy = 1 after edge N. busy falls 2**add_width edges after N.
- out_reg = 0: a request sampled at edge N updates q and q_valid after edge N.
- out_reg = 1: the same request updates q and q_valid after edge N+1. Back-to-back requests are fully pipelined at one per cycle.
- A clr_req at edge N flushes pending q_valid in the out_reg stage: q_valid is 0 after edge N+1 and q holds.
- rst asserted mid-clear or mid-read: outputs go to their reset values immediately. After release, the clear restarts from address 0.
- Consecutive writes then a read of the same address: the read observes all prior writes; there is no hazard window.

## Test plan
- Reset/init (init_val = 32'hA5A5A5A5, add_width = 4): release rst → busy = 1 for exactly 16 edges. Afterwards, reads of addresses 0..15 all return A5A5A5A5 with q_valid pulses.
- Byte enables: write addr 3 with data = 32'h11223344, be = 4'b0101 over A5A5A5A5 → a read of addr 3 returns 32'hA522A544.
- RDW modes: ram[5] = 0. Write 32'hDEADBEEF, be = 4'hF, read_ena = 1, addr 5 → q = 0 with rdw_mode = 0, q = DEADBEEF with rdw_mode = 1.
- Latency: out_reg = 1, reads of addresses 0,1,2 on consecutive edges → q_valid high for 3 cycles starting 2 edges after the first request, with data in order.
- Clear precedence: in READY, drive clr_req = 1 together with write_ena = 1 at addr 7 → the write is dropped, busy = 1 for 16 edges, and a later read of addr 7 returns init_val.
- Mid-clear reset and ignore: write_ena during busy has no effect. Asserting rst at clear count 9 → after release, busy lasts a full 16 edges again and q = 0 throughout.
